// File: rtl/rs_alu_if.sv
// Reservation-station operand payload and the bundle of dispatch, wakeup,
// select and issue signals shared between the ALU reservation station and its
// neighbours (rename/dispatch, writeback buses, ALU, ROB, branch unit).
package rs_alu_pkg;
    typedef struct packed {
        logic       valid;
        logic [6:0] opcode;
        logic [2:0] func3;
        logic [6:0] func7;
        logic [31:0] imm;
        logic [6:0] pd;
        logic [6:0] ps1;
        logic [6:0] ps2;
        logic       ps1_ready;
        logic       ps2_ready;
        logic [4:0] rob_index;
        logic [1:0] fu;
    } rs_data_t;
endpackage

interface rs_alu_if #(
    parameter int N_WB = 3
);
    import rs_alu_pkg::*;

    logic                      dispatch_valid;
    rs_data_t                  dispatch_data;
    logic                      rs_full;
    logic [N_WB-1:0]           wb_valid;
    logic [N_WB-1:0][6:0]      wb_pd;
    logic                      alu_ready;
    logic [4:0]                curr_rob_tag;
    logic                      mispredict;
    logic [4:0]                mispredict_tag;
    logic                      issued;
    rs_data_t                  data_out;
    logic [6:0]                ps1_idx;
    logic [6:0]                ps2_idx;

    // Reservation-station side
    modport slave (
        input  dispatch_valid, dispatch_data, wb_valid, wb_pd, alu_ready,
               curr_rob_tag, mispredict, mispredict_tag,
        output rs_full, issued, data_out, ps1_idx, ps2_idx
    );

    // Environment side (dispatch, writeback, ALU, branch unit)
    modport master (
        output dispatch_valid, dispatch_data, wb_valid, wb_pd, alu_ready,
               curr_rob_tag, mispredict, mispredict_tag,
        input  rs_full, issued, data_out, ps1_idx, ps2_idx
    );
endinterface

// File: rtl/rs_alu.sv
// ALU reservation station: DEPTH entries, lowest-free-slot allocation,
// tag-broadcast wakeup on N_WB writeback ports, lowest-index select of one
// ready entry per cycle, and ROB-window flush on branch mispredict.
module rs_alu
    import rs_alu_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int N_WB  = 3
) (
    input  logic   clk,
    input  logic   reset,
    rs_alu_if.slave bus
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] w_valid;
    logic [DEPTH-1:0] w_elig;
    logic [DEPTH-1:0] w_alloc;
    logic [DEPTH-1:0] w_issue;
    rs_data_t         w_ent [DEPTH];

    logic [IW-1:0]    w_free_idx;
    logic [IW-1:0]    w_sel_idx;
    logic             w_sel_any;
    logic             w_full;
    logic             w_do_disp;
    logic             w_do_issue;
    rs_data_t         w_sel_data;

    logic             r_issued;
    rs_data_t         r_data_out;

    // Full is taken from registered valid bits only, so a slot freed at an
    // issue edge becomes visible to dispatch one cycle later.
    assign w_full     = &w_valid;
    assign w_do_disp  = bus.dispatch_valid && !w_full && !bus.mispredict;
    assign w_do_issue = bus.alu_ready && !bus.mispredict && w_sel_any;

    // Priority pick of lowest free slot and lowest eligible slot (descending
    // scan so the lowest index is written last and wins).
    always_comb begin
        w_free_idx = '0;
        w_sel_idx  = '0;
        w_sel_any  = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!w_valid[i]) w_free_idx = IW'(i);
            if (w_elig[i]) begin
                w_sel_any = 1'b1;
                w_sel_idx = IW'(i);
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            w_alloc[i] = w_do_disp  && (w_free_idx == IW'(i));
            w_issue[i] = w_do_issue && (w_sel_idx  == IW'(i));
        end
    end

    // Payload of the selected entry, tagged valid for the ALU.
    always_comb begin
        w_sel_data       = w_ent[w_sel_idx];
        w_sel_data.valid = 1'b1;
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        rs_alu_entry #(.N_WB(N_WB)) u_ent (
            .clk          (clk),
            .reset        (reset),
            .i_alloc      (w_alloc[g]),
            .i_din        (bus.dispatch_data),
            .i_issue      (w_issue[g]),
            .i_wb_valid   (bus.wb_valid),
            .i_wb_pd      (bus.wb_pd),
            .i_mispredict (bus.mispredict),
            .i_mis_tag    (bus.mispredict_tag),
            .i_curr_tag   (bus.curr_rob_tag),
            .o_valid      (w_valid[g]),
            .o_eligible   (w_elig[g]),
            .o_data       (w_ent[g])
        );
    end

    // Issue register toward the ALU; cleared whenever nothing is selected.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_issued   <= 1'b0;
            r_data_out <= '0;
        end else if (w_do_issue) begin
            r_issued   <= 1'b1;
            r_data_out <= w_sel_data;
        end else begin
            r_issued   <= 1'b0;
            r_data_out <= '0;
        end
    end

    assign bus.rs_full  = w_full;
    assign bus.issued   = r_issued;
    assign bus.data_out = r_data_out;
    assign bus.ps1_idx  = r_data_out.ps1;
    assign bus.ps2_idx  = r_data_out.ps2;
endmodule

// One reservation-station slot: payload, valid and per-operand ready bits.
module rs_alu_entry
    import rs_alu_pkg::*;
#(
    parameter int N_WB = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_alloc,
    input  rs_data_t             i_din,
    input  logic                 i_issue,
    input  logic [N_WB-1:0]      i_wb_valid,
    input  logic [N_WB-1:0][6:0] i_wb_pd,
    input  logic                 i_mispredict,
    input  logic [4:0]           i_mis_tag,
    input  logic [4:0]           i_curr_tag,
    output logic                 o_valid,
    output logic                 o_eligible,
    output rs_data_t             o_data
);
    logic     r_valid;
    logic     r_rdy1;
    logic     r_rdy2;
    rs_data_t r_data;

    logic       w_wake1, w_wake2;
    logic       w_new1, w_new2;
    logic [4:0] w_dist;
    logic [4:0] w_span;
    logic       w_flush;

    // Tag match against every broadcast port; physical reg 0 never wakes.
    always_comb begin
        w_wake1 = 1'b0;
        w_wake2 = 1'b0;
        w_new1  = 1'b0;
        w_new2  = 1'b0;
        for (int k = 0; k < N_WB; k++) begin
            if (i_wb_valid[k] && (i_wb_pd[k] != 7'd0)) begin
                if (i_wb_pd[k] == r_data.ps1) w_wake1 = 1'b1;
                if (i_wb_pd[k] == r_data.ps2) w_wake2 = 1'b1;
                if (i_wb_pd[k] == i_din.ps1)  w_new1  = 1'b1;
                if (i_wb_pd[k] == i_din.ps2)  w_new2  = 1'b1;
            end
        end
    end

    // Younger-than-branch window: distance from the branch, modulo 32, must
    // be nonzero and short of the tail distance. Tail one past the branch
    // (span 1) yields an empty window.
    assign w_dist  = r_data.rob_index - i_mis_tag;
    assign w_span  = i_curr_tag - i_mis_tag;
    assign w_flush = i_mispredict && r_valid && (w_dist != 5'd0) && (w_dist < w_span);

    // Slot state: flush/issue clear valid; allocation loads payload and
    // initial readiness; otherwise accumulate wakeups.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_rdy1  <= 1'b0;
            r_rdy2  <= 1'b0;
            r_data  <= '0;
        end else if (w_flush || i_issue) begin
            r_valid <= 1'b0;
        end else if (i_alloc) begin
            r_valid <= 1'b1;
            r_data  <= i_din;
            r_rdy1  <= i_din.ps1_ready || (i_din.ps1 == 7'd0) || w_new1;
            r_rdy2  <= i_din.ps2_ready || (i_din.ps2 == 7'd0) || w_new2;
        end else if (r_valid) begin
            r_rdy1  <= r_rdy1 || w_wake1;
            r_rdy2  <= r_rdy2 || w_wake2;
        end
    end

    assign o_valid    = r_valid;
    assign o_eligible = r_valid && r_rdy1 && r_rdy2;
    assign o_data     = r_data;
endmodule

// File: doc/rs_alu.md
RS_ALU -- requirements
Module: rs_alu

Interface
REQ-001 Parameter DEPTH, default 8, number of reservation-station entries (power of two, 2..16).
REQ-002 Parameter N_WB, default 3, number of writeback/wakeup broadcast ports.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 dispatch_valid  in  1  rename/dispatch presents one ALU instruction this cycle.
REQ-006 dispatch_data  in  rs_data  fields used: Opcode, func3, func7, imm, pd[6:0], ps1[6:0], ps2[6:0], ps1_ready, ps2_ready, rob_index[4:0], fu.
REQ-007 rs_full  out  1  combinational; 1 when all DEPTH entries are valid.
REQ-008 wb_valid  in  N_WB  per-port broadcast valid (port 0 is fu_alu_done from the ALU).
REQ-009 wb_pd  in  N_WB x 7  per-port physical destination tag being written.
REQ-010 alu_ready  in  1  ALU accepts an issue this cycle.
REQ-011 curr_rob_tag  in  5  ROB tail (next allocation index).
REQ-012 mispredict  in  1  branch mispredict, one-cycle pulse.
REQ-013 mispredict_tag  in  5  ROB index of the mispredicted branch.
REQ-014 issued  out  1  registered; ALU input is valid this cycle.
REQ-015 data_out  out  rs_data  registered; instruction issued to the ALU, valid=1 when issued=1.
REQ-016 ps1_idx, ps2_idx  out  7 each  combinational copies of data_out.ps1/ps2 driving the PRF read ports.

Function
REQ-017 Each entry holds valid, all dispatch_data fields and separate rdy1/rdy2 bits.
REQ-018 Dispatch: if dispatch_valid=1, rs_full=0 and mispredict=0, the instruction is written into the lowest-indexed invalid entry at the next edge; otherwise it is dropped (dispatch SHALL NOT be presented while full).
REQ-019 rs_full is computed from registered valid bits only; a slot freed by issue on edge N is usable by dispatch in cycle N+1, not earlier.
REQ-020 At dispatch, rdyX = dispatch_data.psX_ready OR psX==0 OR (any wb_valid[k] with wb_pd[k]==psX in the same cycle).
REQ-021 Wakeup: for every valid entry, any wb_valid[k] with wb_pd[k]==psX sets rdyX at the next edge; writes of pd 0 are ignored.
REQ-022 An entry is eligible when valid, rdy1=1 and rdy2=1 in registered state; an entry woken in cycle N becomes eligible in cycle N+1 (no same-cycle wakeup-to-select).
REQ-023 Select: when alu_ready=1 and mispredict=0, the lowest-indexed eligible entry is chosen; at the next edge, issued<=1, data_out<=that entry, and the entry is invalidated.
REQ-024 If no entry is eligible, alu_ready=0 or mispredict=1, the next edge sets issued<=0 and data_out<='0.
REQ-025 Throughput: at most one issue per cycle; issue latency from dispatch with both operands ready = 2 edges (write edge, issue edge).
REQ-026 Flush: on mispredict=1, every entry whose rob_index lies strictly between mispredict_tag and curr_rob_tag (circular mod 32, exclusive of both ends) is invalidated at the next edge.
REQ-027 Flush takes priority over wakeup and select for the same entry in the same cycle; entries outside the window keep state and still receive wakeups.
REQ-028 mispredict_tag+1 == curr_rob_tag gives an empty window: no entry is flushed.
REQ-029 Simultaneous dispatch and issue in one cycle is allowed; the issued slot and the dispatch target are chosen from pre-edge state and never coincide.

Reset
REQ-030 While reset=0 (asynchronous), all entry valid and rdy bits clear, issued=0, data_out='0; rs_full=0 follows.
REQ-031 Reset asserted mid-operation discards all entries and any in-flight issue; first dispatch is accepted at the first rising edge after reset deasserts.

Verification
REQ-032 Ready dispatch: ADDI, ps1=7 ready, imm=5, pd=10, rob=3 -> issued=1, data_out.pd=10, rob_index=3 on second edge; issued=0 the edge after.
REQ-033 Wakeup: SUB dispatched with ps2=20 not ready; wb_valid[0]=1, wb_pd[0]=20 two cycles later -> issued=1 exactly two edges after the broadcast edge.
REQ-034 Fill: dispatch 8 non-ready ops -> rs_full=1; 9th dispatch ignored; wake slot 2 -> issue from slot 2, rs_full=0 next cycle, new dispatch lands in slot 2.
REQ-035 Ordering: slots 1 and 4 both become eligible in the same cycle -> slot 1 issues first, slot 4 next cycle; alu_ready=0 holds both with issued=0.
REQ-036 Flush: entries rob 2,4,5,7; mispredict_tag=3, curr_rob_tag=6 -> rob 4,5 invalidated, rob 2,7 retained; concurrent dispatch dropped, issued=0 next cycle.
REQ-037 Reset: assert reset=0 between edges with 3 valid entries and issued=1 -> issued=0, rs_full=0 immediately without waiting for a clock edge; no stale issue after release.
